// File: rtl/sipo_rx.sv
// sipo_rx -- serial-in parallel-out receiver for the MSB-first serial link.
//
// Samples one qualified bit per clock, assembles WIDTH-bit words MSB first
// and presents each finished word through a one-word holding register on a
// ready/valid interface. A word that finishes while the holding register is
// still occupied (and not being accepted) is dropped and flagged on the
// sticky overrun output. A synchronous clear realigns the word framing.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous reset, active-high, clears all state
//   serial_in     serial data bit, sampled when serial_valid=1
//   serial_valid  qualifies serial_in for this cycle
//   clear         synchronous framing reset, also clears overrun
//   parallel_out  assembled word, first-received bit in the MSB
//   out_valid     parallel_out holds an unconsumed word
//   out_ready     downstream accepts when out_valid && out_ready
//   bit_count     bits collected in the current partial word (0..WIDTH-1)
//   overrun       sticky: at least one completed word was dropped
module sipo_rx #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    bit_count,
  output logic             overrun
);

  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             vld_q, vld_d;
  logic             ovr_q, ovr_d;

  logic             accept;
  logic [WIDTH-1:0] word;

  assign accept = vld_q && out_ready;
  assign word   = {sh_q[WIDTH-2:0], serial_in};

  always_comb begin
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    hold_d = hold_q;
    vld_d  = vld_q;
    ovr_d  = ovr_q;

    // A consumed word frees the holding register; a word completing at the
    // same edge re-fills it below, so out_valid stays high in that case.
    if (accept) begin
      vld_d = 1'b0;
    end

    if (clear) begin
      // Clear beats serial_valid; the holding register is left alone so a
      // word already presented survives the realignment.
      sh_d  = '0;
      cnt_d = '0;
      ovr_d = 1'b0;
    end else if (serial_valid) begin
      sh_d = word;
      if (cnt_q == LAST_IDX) begin
        cnt_d = '0;
        if (!vld_q || accept) begin
          hold_d = word;
          vld_d  = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Register stage: all state, all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      hold_q <= '0;
      vld_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
      vld_q  <= vld_d;
      ovr_q  <= ovr_d;
    end
  end

  assign parallel_out = hold_q;
  assign out_valid    = vld_q;
  assign bit_count    = cnt_q;
  assign overrun      = ovr_q;

endmodule

// File: doc/sipo_rx.md
# sipo_rx

Serial-in parallel-out receiver: the receive end of the team's MSB-first serial link, which our parallel-in serial-out shifter drives. The block samples one qualified bit per clock, assembles WIDTH-bit words MSB first, and presents each word on a ready/valid output with a one-word holding register. A word that completes while the holding register is still full is dropped and flagged by a sticky overrun flag. A synchronous clear realigns the word framing.

## Interface
- WIDTH, default 4: word width in bits; legal range 2..32.
- CW, default $clog2(WIDTH): width of bit_count; derived parameter, do not override.

- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous reset, active-high. Clears all state immediately.
- serial_in  input  1  serial data bit; sampled only when serial_valid=1.
- serial_valid  input  1  qualifies serial_in for this cycle.
- clear  input  1  synchronous framing reset; also clears overrun.
- parallel_out  output  WIDTH  assembled word; the first-received bit is in the MSB.
- out_valid  output  1  parallel_out holds an unconsumed word.
- out_ready  input  1  downstream accepts the word when out_valid && out_ready.
- bit_count  output  CW  number of bits of the current partial word (0..WIDTH-1).
- overrun  output  1  sticky: at least one completed word was dropped.

## Operation
- State: shift register sh[WIDTH-1:0], counter cnt (drives bit_count), holding register hold (drives parallel_out), out_valid, overrun. All outputs are registered.
- Reset (rst=1, asynchronous): sh=0, cnt=0, parallel_out=0, out_valid=0, overrun=0.
- Accept: when out_valid && out_ready, the word is consumed. out_valid falls at the next edge unless a new word loads at that same edge.
- Shift: when serial_valid=1 and clear=0:
  - sh <= {sh[WIDTH-2:0], serial_in}.
  - If cnt < WIDTH-1, cnt <= cnt+1.
- Word complete: serial_valid=1, clear=0 and cnt==WIDTH-1.
  - Set cnt <= 0 and form word = {sh[WIDTH-2:0], serial_in}.
  - If out_valid=0, or an accept happens in the same cycle: parallel_out <= word and out_valid <= 1.
  - Else (out_valid=1, out_ready=0): drop the word, keep parallel_out and out_valid unchanged, set overrun <= 1.
- serial_valid=0: sh and cnt hold. Gaps between bits are allowed anywhere, including inside a word.
- clear=1 (takes priority over serial_valid):
  - sh <= 0, cnt <= 0, overrun <= 0.
  - The serial bit sampled in that cycle is discarded.
  - parallel_out, out_valid and the accept handshake are unaffected, so a held word survives a clear.
- overrun stays at 1 until clear or rst. It never clears on its own.
- parallel_out changes only when a new word loads. It is stable while out_valid=1 and out_ready=0.

## Timing
- Latency: the last bit of a word is sampled at edge N; parallel_out and out_valid are updated after edge N. That is zero extra cycles beyond the final sample.
- Throughput: with serial_valid held at 1 and out_ready=1, one word every WIDTH cycles, back to back with no gap cycle.
- Simultaneous completion and accept at edge N: the old word is consumed, the new word loads, and out_valid stays 1. No overrun.
- Simultaneous completion and clear: clear wins. No word loads and cnt=0.
- rst asserted mid-word: the partial word is lost. After release, the first qualified bit is bit 0 (MSB) of a new word.
- The input has no combinational path to any output.

## Test plan
- Reset values: assert rst mid-word with out_valid=1 and overrun=1. Required: all outputs read 0 immediately, without waiting for a clock edge.
- Basic word (WIDTH=4): send bits 1,0,1,1 on consecutive cycles with out_ready=1. Required: parallel_out=4'b1011 and out_valid=1 on the cycle after the 4th bit; bit_count steps 1,2,3,0.
- Gapped input: send 1,0,1,0 with two-cycle serial_valid=0 gaps. Required: 4'b1010; bit_count holds during the gaps.
- Backpressure and overrun: with out_ready=0, send 4'hA then 4'h5. Required: parallel_out stays 4'hA, overrun=1. Then raise out_ready. Required: one accept, out_valid falls, overrun stays 1.
- Back-to-back words: out_ready=1, continuous stream 4'h3,4'hC,4'hF. Required: out_valid is continuously 1 for the 3 word-load cycles with the correct values, and overrun stays 0.
- Clear: after 2 bits, assert clear for one cycle while serial_valid=1, then send 4'h9. Required: bit_count=0 after the clear, received word is 4'h9, overrun reads 0, and a previously held word is still presented.
